// File: rtl/truth_table_sweep.sv
// Stimulus/capture sweep for a 3-input circuit: drives all 8 rows, samples out, and checks against EXPECTED_TT.
// Optional macro SWEEP_GRAY_ORDER_EN applies rows in Gray order instead of binary order.
//
// state  | meaning
// IDLE   | drive 000, wait for start
// APPLY  | hold current row while the dwell counter runs down
// SAMPLE | capture synchronized out into tt_obs[7-r], advance or finish
// DONE   | one-cycle done pulse, match/err_cnt valid
module truth_table_sweep #(
    parameter logic [7:0] EXPECTED_TT = 8'h6F,
    parameter int         SETTLE      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt_obs,
    output logic       match,
    output logic [3:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    // Down-counter reload; reaching zero after SETTLE APPLY cycles.
    localparam logic [7:0] DWELL_LOAD = 8'(SETTLE - 1);

    state_t     state, state_nxt;
    logic [7:0] dwell_cnt;
    logic [2:0] step;
    logic       sync_q1, sync_q2;

    logic       load_first, load_next, capture, finish, cancel;
    logic [2:0] row_cur;
    logic [2:0] tt_idx;
    logic [7:0] tt_next;
    logic [7:0] tt_diff;
    logic [3:0] err_next;

    function automatic logic [2:0] row_of(input logic [2:0] s);
`ifdef SWEEP_GRAY_ORDER_EN
        return s ^ {1'b0, s[2:1]};
`else
        return s;
`endif
    endfunction

    assign row_cur = {in1, in2, in3};
    assign tt_idx  = 3'd7 - row_cur;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= dut_out;
            sync_q2 <= sync_q1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load_first = 1'b0;
        load_next  = 1'b0;
        capture    = 1'b0;
        finish     = 1'b0;
        cancel     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = APPLY;
                    load_first = 1'b1;
                end
            end
            APPLY: begin
                if (abort) begin
                    state_nxt = IDLE;
                    cancel    = 1'b1;
                end else if (dwell_cnt == 8'd0) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                // abort wins over the capture of this row
                if (abort) begin
                    state_nxt = IDLE;
                    cancel    = 1'b1;
                end else begin
                    capture = 1'b1;
                    if (step == 3'd7) begin
                        state_nxt = DONE;
                        finish    = 1'b1;
                    end else begin
                        state_nxt = APPLY;
                        load_next = 1'b1;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tt_next         = tt_obs;
        tt_next[tt_idx] = sync_q2;
        tt_diff         = tt_next ^ EXPECTED_TT;
        err_next        = 4'd0;
        for (int i = 0; i < 8; i++) begin
            err_next = err_next + 4'(tt_diff[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {in1, in2, in3} <= 3'b000;
            step            <= 3'd0;
            dwell_cnt       <= 8'd0;
            tt_obs          <= 8'h00;
            match           <= 1'b0;
            err_cnt         <= 4'd0;
        end else if (load_first) begin
            {in1, in2, in3} <= row_of(3'd0);
            step            <= 3'd0;
            dwell_cnt       <= DWELL_LOAD;
            tt_obs          <= 8'h00;
            match           <= 1'b0;
            err_cnt         <= 4'd0;
        end else if (cancel) begin
            {in1, in2, in3} <= 3'b000;
        end else if (capture) begin
            tt_obs <= tt_next;
            if (finish) begin
                match           <= (tt_next == EXPECTED_TT);
                err_cnt         <= err_next;
                {in1, in2, in3} <= 3'b000;
            end else if (load_next) begin
                step            <= step + 3'd1;
                {in1, in2, in3} <= row_of(step + 3'd1);
                dwell_cnt       <= DWELL_LOAD;
            end
        end else if (state == APPLY && dwell_cnt != 8'd0) begin
            dwell_cnt <= dwell_cnt - 8'd1;
        end
    end

endmodule

// File: tb/tb_truth_table_sweep.sv
// Directed bench for truth_table_sweep: behavioural out = in1 | (in2 ^ in3), SETTLE = 4.
// Edge k counts posedges after the edge following which start is driven (edge 0).
module tb_truth_table_sweep;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       stuck = 1'b0;
    logic       dut_out;
    logic       in1, in2, in3, busy, done, match;
    logic [7:0] tt_obs;
    logic [3:0] err_cnt;

    always #5 clk = ~clk;

    assign dut_out = stuck | in1 | (in2 ^ in3);

    truth_table_sweep #(.EXPECTED_TT(8'h6F), .SETTLE(4)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .dut_out (dut_out),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .busy    (busy),
        .done    (done),
        .tt_obs  (tt_obs),
        .match   (match),
        .err_cnt (err_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    int          done_edge, done_cnt;
    logic [2:0]  drv_seq[$];
    logic        busy_e1, busy_e41, busy_e42, busy_e43;
    logic [7:0]  tt_e43;
    logic        abort_busy;
    logic [2:0]  abort_drv;
    logic [17:0] rst_snap;
    logic [2:0]  exp_seq[9];

    // One sweep window of 44 edges; optional start re-pulses, abort and reset injection.
    task automatic sweep(input bit repulse, input int abort_k, input int rst_k);
        logic [2:0] drv;
        done_edge = -1;
        done_cnt  = 0;
        drv_seq.delete();
        @(posedge clk); #1 start = 1'b1;
        for (int k = 1; k <= 44; k++) begin
            @(posedge clk); #1;
            start = repulse && (k == 10 || k == 41 || k == 42);
            abort = (k == abort_k);
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1 rst_snap = {in1, in2, in3, busy, done, match, err_cnt, tt_obs};
            end else if (rst_k > 0 && k == rst_k + 1) begin
                rst_n = 1'b1;
            end
            @(negedge clk);
            drv = {in1, in2, in3};
            if (k == 1) begin
                busy_e1 = busy;
                drv_seq.push_back(drv);
            end else if (drv != drv_seq[$]) begin
                drv_seq.push_back(drv);
            end
            if (done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = k;
            end
            if (k == 41) busy_e41 = busy;
            if (k == 42) busy_e42 = busy;
            if (k == 43) begin
                busy_e43 = busy;
                tt_e43   = tt_obs;
            end
            if (k == abort_k + 1) begin
                abort_busy = busy;
                abort_drv  = drv;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
`ifdef SWEEP_GRAY_ORDER_EN
        exp_seq = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0};
`else
        exp_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
`endif
        #12;
        check("rst_drive", {in1, in2, in3}, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_tt", tt_obs, 8'h00);
        check("rst_match", match, 1'b0);
        check("rst_err", err_cnt, 4'd0);
        @(negedge clk) rst_n = 1'b1;

        // nominal sweep
        sweep(1'b0, -1, -1);
        check("t1_done_edge", done_edge, 41);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_busy_e1", busy_e1, 1'b1);
        check("t1_busy_e41", busy_e41, 1'b1);
        check("t1_busy_e42", busy_e42, 1'b0);
        check("t1_tt", tt_obs, 8'h6F);
        check("t1_match", match, 1'b1);
        check("t1_err", err_cnt, 4'd0);
        check("t1_seq_len", drv_seq.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < drv_seq.size()) check($sformatf("t1_seq%0d", i), drv_seq[i], exp_seq[i]);
        end

        // stuck-at-1 circuit
        stuck = 1'b1;
        sweep(1'b0, -1, -1);
        stuck = 1'b0;
        check("t2_done_edge", done_edge, 41);
        check("t2_tt", tt_obs, 8'hFF);
        check("t2_match", match, 1'b0);
        check("t2_err", err_cnt, 4'd2);

        // start re-pulses while busy and in DONE are ignored; next one restarts
        sweep(1'b1, -1, -1);
        check("t3_done_cnt", done_cnt, 1);
        check("t3_done_edge", done_edge, 41);
        check("t3_restart_busy", busy_e43, 1'b1);
        check("t3_restart_tt", tt_e43, 8'h00);
        pulse_reset();

        // abort while row 3 is applied
        sweep(1'b0, 17, -1);
        check("t4_busy", abort_busy, 1'b0);
        check("t4_drive", abort_drv, 3'b000);
        check("t4_done_cnt", done_cnt, 0);
        check("t4_tt_hi", tt_obs[7:5], 3'b011);
        check("t4_tt", tt_obs, 8'h60);
        check("t4_match", match, 1'b0);

        // asynchronous reset mid-sweep, then a clean sweep
        sweep(1'b0, -1, 20);
        check("t5_rst_outputs", rst_snap, 18'h0);
        check("t5_done_cnt", done_cnt, 0);
        sweep(1'b0, -1, -1);
        check("t5_done_edge", done_edge, 41);
        check("t5_tt", tt_obs, 8'h6F);
        check("t5_match", match, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
